// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin memory bus arbiter with fixed-length accesses,
// ROM/RAM chip-select decode and error signalling for illegal accesses.
//
// state    | meaning
// S_IDLE   | bus free, arbitrating between req0/req1
// S_ACCESS | latched request driven onto the memory bus for ACC_CYC cycles
// S_ACK    | one-cycle completion pulse to the owner, bus released
module mem_bus_arbiter #(
   parameter int unsigned ACC_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [12:0] addr0,
   input  logic [12:0] addr1,
   input  logic        we0,
   input  logic        we1,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic [12:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   output logic        mem_wdata_oe,
   input  logic [7:0]  mem_rdata,
   output logic        ram_sel,
   output logic        rom_sel
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_ACK    = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACC_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic        r_last;
   logic        r_owner;
   logic        r_we;
   logic        r_unmap;
   logic        r_err_pend;

   logic        r_gnt0;
   logic        r_gnt1;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_err;
   logic [7:0]  r_rdata;
   logic [12:0] r_mem_addr;
   logic        r_mem_rd;
   logic        r_mem_wr;
   logic [7:0]  r_mem_wdata;
   logic        r_mem_oe;
   logic        r_ram_sel;
   logic        r_rom_sel;

   logic        w_any;
   logic        w_win;
   logic [12:0] w_addr;
   logic        w_we;
   logic [7:0]  w_wdata;
   logic        w_rom;
   logic        w_ram;
   logic        w_unmap;

   // w_win: 1 selects master 1; on a tie the master not granted last wins
   assign w_any   = req0 | req1;
   assign w_win   = (req0 & req1) ? ~r_last : req1;
   assign w_addr  = w_win ? addr1  : addr0;
   assign w_we    = w_win ? we1    : we0;
   assign w_wdata = w_win ? wdata1 : wdata0;
   assign w_rom   = ~w_addr[12];
   assign w_ram   = w_addr[12] & w_addr[11];
   assign w_unmap = w_addr[12] & ~w_addr[11];

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
         S_ACCESS: if (r_cnt == 4'd0) w_state_nxt = S_ACK;
         S_ACK:    w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt       <= 4'd0;
         r_last      <= 1'b1;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_unmap     <= 1'b0;
         r_err_pend  <= 1'b0;
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= 8'h00;
         r_mem_addr  <= 13'h0000;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= 8'h00;
         r_mem_oe    <= 1'b0;
         r_ram_sel   <= 1'b0;
         r_rom_sel   <= 1'b0;
      end else begin
         r_ack0 <= 1'b0;
         r_ack1 <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner     <= w_win;
                  r_last      <= w_win;
                  r_we        <= w_we;
                  r_unmap     <= w_unmap;
                  r_err_pend  <= w_unmap | (w_we & w_rom);
                  r_cnt       <= CNT_LOAD;
                  r_gnt0      <= ~w_win;
                  r_gnt1      <= w_win;
                  r_mem_addr  <= w_addr;
                  r_rom_sel   <= w_rom;
                  r_ram_sel   <= w_ram;
                  r_mem_rd    <= ~w_we & ~w_unmap;
                  r_mem_wr    <= w_we & w_ram;
                  r_mem_oe    <= w_we & w_ram;
                  r_mem_wdata <= (w_we & w_ram) ? w_wdata : 8'h00;
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_gnt0      <= 1'b0;
                  r_gnt1      <= 1'b0;
                  r_mem_addr  <= 13'h0000;
                  r_rom_sel   <= 1'b0;
                  r_ram_sel   <= 1'b0;
                  r_mem_rd    <= 1'b0;
                  r_mem_wr    <= 1'b0;
                  r_mem_oe    <= 1'b0;
                  r_mem_wdata <= 8'h00;
                  r_ack0      <= ~r_owner;
                  r_ack1      <= r_owner;
                  r_err       <= r_err_pend;
                  // unmapped reads return zero instead of bus garbage
                  if (!r_we) r_rdata <= r_unmap ? 8'h00 : mem_rdata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign gnt0         = r_gnt0;
   assign gnt1         = r_gnt1;
   assign ack0         = r_ack0;
   assign ack1         = r_ack1;
   assign err          = r_err;
   assign rdata        = r_rdata;
   assign busy         = (r_state != S_IDLE);
   assign mem_addr     = r_mem_addr;
   assign mem_rd       = r_mem_rd;
   assign mem_wr       = r_mem_wr;
   assign mem_wdata    = r_mem_wdata;
   assign mem_wdata_oe = r_mem_oe;
   assign ram_sel      = r_ram_sel;
   assign rom_sel      = r_rom_sel;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus queues expected completions,
// an independent monitor checks every ack against the queue.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1;
   logic [12:0] addr0, addr1;
   logic        we0, we1;
   logic [7:0]  wdata0, wdata1;
   logic        gnt0, gnt1, ack0, ack1, err;
   logic [7:0]  rdata;
   logic        busy;
   logic [12:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_wdata;
   logic        mem_wdata_oe;
   logic [7:0]  mem_rdata;
   logic        ram_sel, rom_sel;

   typedef struct {
      logic       m;
      logic       err;
      logic       rd;
      logic [7:0] rdata;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_bus_arbiter #(.ACC_CYC(2)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .ack0(ack0), .ack1(ack1),
      .err(err), .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
      .mem_rdata(mem_rdata),
      .ram_sel(ram_sel), .rom_sel(rom_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic m, input logic e, input logic rd, input logic [7:0] d);
      exp_t x;
      x.m = m; x.err = e; x.rd = rd; x.rdata = d;
      q.push_back(x);
   endtask

   function automatic logic [63:0] all_outs();
      return {24'h0, gnt0, gnt1, ack0, ack1, err, rdata, busy, mem_addr,
              mem_rd, mem_wr, mem_wdata, mem_wdata_oe, ram_sel, rom_sel};
   endfunction

   always @(negedge clk) begin
      if (ack0 || ack1) begin
         if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none", ack0, ack1);
         end else begin
            mon_e = q.pop_front();
            check("ack_owner", {ack1, ack0}, mon_e.m ? 64'h2 : 64'h1);
            check("ack_err", err, mon_e.err);
            if (mon_e.rd) check("ack_rdata", rdata, mon_e.rdata);
         end
      end else if (err) begin
         n_cmp++; n_bad++;
         $display("FAIL err_without_ack: got err=1 expected 0");
      end
      if (gnt0 && gnt1) begin
         n_cmp++; n_bad++;
         $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1 expected at most one");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g, prev;
      int ng, last_i;
      reset = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
      we0 = 0; we1 = 0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
      tick(); tick();
      check("reset_outputs", all_outs(), 64'h0);

      // RAM read by master 0
      reset = 1'b1;
      req0 = 1; addr0 = 13'h1802; we0 = 0; mem_rdata = 8'h5A;
      push(1'b0, 1'b0, 1'b1, 8'h5A);
      tick();
      check("rd_acc1", {gnt0, gnt1, busy, mem_rd, mem_wr, ram_sel, rom_sel}, 7'b1011010);
      check("rd_addr", mem_addr, 13'h1802);
      req0 = 0;
      tick();
      check("rd_acc2", {mem_rd, ram_sel, busy}, 3'b111);
      tick();
      check("rd_ack_cycle", {gnt0, mem_rd, ram_sel, busy}, 4'b0001);
      tick();
      check("rd_idle", {busy, rdata}, {1'b0, 8'h5A});

      // tie from reset: both held, grants must alternate 0,1,0,1 every 4 cycles
      reset = 1'b0;
      req0 = 1; req1 = 1; addr0 = 13'h1802; addr1 = 13'h0010; we0 = 0; we1 = 0;
      mem_rdata = 8'h3C;
      tick();
      check("reset_priority", {busy, gnt0, gnt1}, 3'b000);
      reset = 1'b1;
      push(1'b0, 1'b0, 1'b1, 8'h3C);
      push(1'b1, 1'b0, 1'b1, 8'h3C);
      push(1'b0, 1'b0, 1'b1, 8'h3C);
      push(1'b1, 1'b0, 1'b1, 8'h3C);
      prev = 2'b00; ng = 0; last_i = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         g = {gnt1, gnt0};
         if (g != 2'b00 && prev == 2'b00 && ng < 4) begin
            check("tie_owner", g, ((ng % 2) != 0) ? 64'h2 : 64'h1);
            if (ng > 0) check("tie_spacing", i - last_i, 4);
            last_i = i;
            ng++;
            if (ng == 4) begin req0 = 0; req1 = 0; end
         end
         prev = g;
      end
      check("tie_grant_count", ng, 4);
      check("tie_idle", busy, 1'b0);

      // ROM write by master 1: no strobe, err with ack, rdata untouched
      req1 = 1; addr1 = 13'h0010; we1 = 1; wdata1 = 8'hC3;
      push(1'b1, 1'b1, 1'b0, 8'h00);
      tick();
      check("romwr_acc1", {gnt1, rom_sel, ram_sel, mem_wr, mem_wdata_oe, mem_rd}, 6'b110000);
      req1 = 0;
      tick();
      check("romwr_acc2", {rom_sel, mem_wr, mem_wdata_oe}, 3'b100);
      tick();
      check("romwr_rdata_kept", rdata, 8'h3C);
      tick();

      // unmapped read by master 0: nothing on the bus, rdata forced to zero
      req0 = 1; addr0 = 13'h1000; we0 = 0; mem_rdata = 8'hFF;
      push(1'b0, 1'b1, 1'b1, 8'h00);
      tick();
      check("unmap_acc1", {gnt0, busy, rom_sel, ram_sel, mem_rd, mem_wr}, 6'b110000);
      req0 = 0;
      tick();
      check("unmap_acc2", {rom_sel, ram_sel, mem_rd, mem_wr}, 4'b0000);
      tick(); tick();

      // RAM write by master 1
      req1 = 1; addr1 = 13'h1900; we1 = 1; wdata1 = 8'hA5;
      push(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      check("ramwr_acc1", {gnt1, ram_sel, mem_wr, mem_wdata_oe, mem_rd}, 5'b11110);
      check("ramwr_data", mem_wdata, 8'hA5);
      req1 = 0; wdata1 = 8'h00;
      tick();
      check("ramwr_acc2", {mem_wr, mem_wdata_oe, mem_wdata}, {2'b11, 8'hA5});
      tick();
      check("ramwr_ack_cycle", {mem_wr, mem_wdata_oe}, 2'b00);
      check("ramwr_rdata_kept", rdata, 8'h00);
      tick();

      // reset during 2nd ACCESS cycle of a write aborts it without ack
      req0 = 1; addr0 = 13'h1805; we0 = 1; wdata0 = 8'h77;
      tick();
      check("abort_acc1", {gnt0, mem_wr, ram_sel}, 3'b111);
      req0 = 0;
      tick();
      check("abort_acc2", {busy, mem_wr}, 2'b11);
      reset = 1'b0;
      tick();
      check("abort_outputs", all_outs(), 64'h0);
      reset = 1'b1;
      req0 = 1; req1 = 1; addr0 = 13'h1802; we0 = 0; addr1 = 13'h1803; we1 = 0;
      mem_rdata = 8'h42;
      push(1'b0, 1'b0, 1'b1, 8'h42);
      tick();
      check("post_reset_tie", {gnt1, gnt0}, 2'b01);
      req0 = 0; req1 = 0;
      tick(); tick(); tick();

      // inputs changed mid-access are ignored
      req0 = 1; addr0 = 13'h0123; we0 = 0; mem_rdata = 8'h9E;
      push(1'b0, 1'b0, 1'b1, 8'h9E);
      tick();
      check("chg_acc1", {mem_addr, rom_sel, mem_rd}, {13'h0123, 2'b11});
      req0 = 0; addr0 = 13'h1FFF; we0 = 1;
      tick();
      check("chg_acc2", {mem_addr, rom_sel, mem_rd, mem_wr}, {13'h0123, 3'b110});
      tick(); tick(); tick();

      check("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, range 1..15: memory access length in clk cycles.
REQ-002 SHALL have ports, in this order:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-low.
- req0, req1  input  1 each  access request, master 0 / master 1.
- addr0, addr1  input  13 each  master byte address.
- we0, we1  input  1 each  1 = write, 0 = read.
- wdata0, wdata1  input  8 each  master write data.
- gnt0, gnt1  output  1 each  master owns the bus.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- err  output  1  one-cycle error pulse, coincident with ack.
- rdata  output  8  read data, valid with ack, then held.
- busy  output  1  state is not IDLE.
- mem_addr  output  13  memory address.
- mem_rd, mem_wr  output  1 each  memory read / write strobe.
- mem_wdata  output  8  memory write data.
- mem_wdata_oe  output  1  write-data drive enable, for the top-level tristate.
- mem_rdata  input  8  memory read data.
- ram_sel, rom_sel  output  1 each  decoded chip selects.

Function
REQ-003 SHALL implement a three-state FSM:
- IDLE -> ACCESS when any req is high.
- ACCESS -> ACK when the cycle counter reaches 0.
- ACK -> IDLE unconditionally.
REQ-004 On the IDLE->ACCESS edge, SHALL latch the winner's addr, we and wdata, load the counter with ACC_CYC-1, and set the winner's gnt.
REQ-005 Arbitration SHALL be round-robin: with one req high, that master wins; with both high, the master not granted last wins.
REQ-006 The last-granted pointer SHALL update only on a grant.
REQ-007 In ACCESS, all mem_* and select outputs SHALL be registered, derived from the latched request, and stable for exactly ACC_CYC cycles. All SHALL be 0 in IDLE and ACK.
REQ-008 Address decode SHALL be: rom_sel = (addr[12]==0); ram_sel = (addr[12:11]==2'b11); addr[12:11]==2'b10 is unmapped.
REQ-009 Read: mem_rd SHALL be 1 for all ACCESS cycles; mem_rdata SHALL be captured into rdata on the last ACCESS cycle.
REQ-010 Write: mem_wr and mem_wdata_oe SHALL be 1 for all ACCESS cycles, with mem_wdata equal to the latched wdata.
REQ-011 A write to ROM space SHALL keep mem_wr=0 and mem_wdata_oe=0, still take ACC_CYC cycles, and pulse err with ack.
REQ-012 An unmapped access SHALL assert neither select nor strobe, SHALL load rdata with 8'h00 on a read, and SHALL pulse err with ack.
REQ-013 In ACK, SHALL pulse the owner's ack (and err if applicable) for exactly one cycle, and gnt SHALL drop. No arbitration SHALL occur in ACK.
REQ-014 rdata SHALL hold its value until the next completed read; writes SHALL NOT change rdata.
REQ-015 Request timing:
- A req sampled high in IDLE at edge n puts the bus in ACCESS for cycles n+1..n+ACC_CYC and asserts ack in cycle n+ACC_CYC+1.
- Minimum spacing between grants is ACC_CYC+2 cycles.
REQ-016 Changes to req, addr, we or wdata during ACCESS or ACK SHALL be ignored. A req dropped mid-access SHALL still complete and receive ack (no abort).
REQ-017 A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-018 busy SHALL be 1 in ACCESS and ACK, and 0 in IDLE.
REQ-019 gnt0 and gnt1 SHALL never be 1 simultaneously; ack0 and ack1 likewise.

Reset
REQ-020 When reset=0 at a rising clk edge, SHALL enter IDLE, clear the counter, and set the last-granted pointer to master 1 (master 0 wins the first tie).
REQ-021 Reset SHALL drive all outputs to 0, including rdata=8'h00 and mem_addr=13'h0000.
REQ-022 Reset asserted mid-access SHALL abort the access with no ack, and SHALL have mem_rd/mem_wr at 0 in the cycle after the reset edge.
REQ-023 Reset SHALL take priority over all other inputs.

Verification
REQ-024 Setup: ACC_CYC=2. The bench SHALL cover the following directed scenarios:
- Read: req0, addr0=13'h1802, we0=0, mem_rdata=8'h5A -> mem_rd and ram_sel high for 2 cycles, ack0 one cycle later, rdata=8'h5A, err=0.
- Tie: req0 and req1 high from reset -> master 0 served first, then master 1. Both held high -> grants alternate 0,1,0,1 with 4-cycle spacing.
- ROM write: req1, addr1=13'h0010, we1=1, wdata1=8'hC3 -> rom_sel high, mem_wr never high, ack1 and err pulse together.
- Unmapped read: req0, addr0=13'h1000, we0=0 -> no select or strobe, rdata=8'h00, err pulses.
- Abort: reset=0 during the 2nd ACCESS cycle of a write to 13'h1805 -> next cycle all outputs 0, no ack. After release, req0 high -> master 0 granted.
- Mid-access change: req0 dropped and addr0 changed during ACCESS -> mem_addr unchanged, ack0 still pulses.
